// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter and its read-return tracker.
package sram_port_arbiter_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

    localparam logic [3:0] BYTEEN_FULL    = 4'hF;
    localparam int         RD_LATENCY_MAX = 4;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/sram_rd_tracker.sv
// Shift pipeline of in-flight reads {valid, owner}; the last stage marks the
// cycle in which mem_rdata belongs to the recorded owner.
module sram_rd_tracker
    import sram_port_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic HCLK,
    input  logic HRESETN,
    input  logic i_valid,
    input  logic i_owner,
    output logic o_rvalid_a,
    output logic o_rvalid_b
);

    logic [RD_LATENCY-1:0] r_vld;
    logic [RD_LATENCY-1:0] r_own;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_vld <= '0;
            r_own <= '0;
        end else begin
            r_vld[0] <= i_valid;
            r_own[0] <= i_owner;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_own[i] <= r_own[i-1];
            end
        end
    end

    assign o_rvalid_a = r_vld[RD_LATENCY-1] && (r_own[RD_LATENCY-1] == REQ_A);
    assign o_rvalid_b = r_vld[RD_LATENCY-1] && (r_own[RD_LATENCY-1] == REQ_B);

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with per-requester lock, sharing one fabric SRAM port
// between requesters a and b; reads return RD_LATENCY cycles after mem_ren.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int MEM_AWIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  req_a,
    input  logic                  lock_a,
    input  logic                  write_a,
    input  logic [MEM_AWIDTH-1:0] addr_a,
    input  logic [3:0]            byteen_a,
    input  logic [31:0]           wdata_a,
    input  logic                  req_b,
    input  logic                  lock_b,
    input  logic                  write_b,
    input  logic [MEM_AWIDTH-1:0] addr_b,
    input  logic [3:0]            byteen_b,
    input  logic [31:0]           wdata_b,
    output logic                  gnt_a,
    output logic                  rvalid_a,
    output logic [31:0]           rdata_a,
    output logic                  gnt_b,
    output logic                  rvalid_b,
    output logic [31:0]           rdata_b,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [3:0]            mem_byteen,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    req_id_e               r_ptr;
    req_id_e               r_last_id;
    logic                  r_last_vld;
    req_id_e               r_owner;
    logic                  r_mem_ren;
    logic                  r_mem_wen;
    logic [MEM_AWIDTH-1:0] r_mem_addr;
    logic [3:0]            r_mem_byteen;
    logic [31:0]           r_mem_wdata;

    logic                  w_lock_a;
    logic                  w_lock_b;
    logic                  w_win_a;
    logic                  w_win_b;
    logic                  w_any;
    req_id_e               w_win_id;
    logic                  w_write;
    logic [MEM_AWIDTH-1:0] w_addr;
    logic [3:0]            w_byteen;
    logic [31:0]           w_wdata;
    logic                  w_rvalid_a;
    logic                  w_rvalid_b;

    // A lock only holds the port if the locking requester owns the last grant.
    assign w_lock_a = lock_a && r_last_vld && (r_last_id == REQ_A);
    assign w_lock_b = lock_b && r_last_vld && (r_last_id == REQ_B);

    always_comb begin
        w_win_a = 1'b0;
        w_win_b = 1'b0;
        if (w_lock_a) begin
            w_win_a = req_a;
        end else if (w_lock_b) begin
            w_win_b = req_b;
        end else if (req_a && req_b) begin
            w_win_a = (r_ptr == REQ_A);
            w_win_b = (r_ptr == REQ_B);
        end else begin
            w_win_a = req_a;
            w_win_b = req_b;
        end
    end

    // Winner logic feeds the flops ungated; only the visible grants are masked by reset.
    assign gnt_a    = w_win_a && HRESETN;
    assign gnt_b    = w_win_b && HRESETN;
    assign w_any    = w_win_a || w_win_b;
    assign w_win_id = w_win_b ? REQ_B : REQ_A;
    assign w_write  = w_win_b ? write_b  : write_a;
    assign w_addr   = w_win_b ? addr_b   : addr_a;
    assign w_byteen = w_win_b ? byteen_b : byteen_a;
    assign w_wdata  = w_win_b ? wdata_b  : wdata_a;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_ptr        <= REQ_A;
            r_last_id    <= REQ_A;
            r_last_vld   <= 1'b0;
            r_owner      <= REQ_A;
            r_mem_ren    <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_byteen <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_mem_ren <= 1'b0;
            r_mem_wen <= 1'b0;
            if (w_any) begin
                r_ptr        <= other_req(w_win_id);
                r_last_id    <= w_win_id;
                r_last_vld   <= 1'b1;
                r_owner      <= w_win_id;
                r_mem_ren    <= !w_write;
                r_mem_wen    <= w_write;
                r_mem_addr   <= w_addr;
                r_mem_byteen <= w_write ? w_byteen : BYTEEN_FULL;
                r_mem_wdata  <= w_wdata;
            end
        end
    end

    assign mem_ren    = r_mem_ren;
    assign mem_wen    = r_mem_wen;
    assign mem_addr   = r_mem_addr;
    assign mem_byteen = r_mem_byteen;
    assign mem_wdata  = r_mem_wdata;

    sram_rd_tracker #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_tracker (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .i_valid   (r_mem_ren),
        .i_owner   (r_owner),
        .o_rvalid_a(w_rvalid_a),
        .o_rvalid_b(w_rvalid_b)
    );

    assign rvalid_a = w_rvalid_a;
    assign rvalid_b = w_rvalid_b;
    assign rdata_a  = w_rvalid_a ? mem_rdata : 32'h0;
    assign rdata_b  = w_rvalid_b ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter; three instances with RD_LATENCY 1, 2, 3
// share the same stimulus and each is checked in the scenarios that need it.
module tb_sram_port_arbiter;

    localparam int AW = 16;

    logic          HCLK = 1'b0;
    logic          HRESETN = 1'b0;
    logic          req_a, lock_a, write_a, req_b, lock_b, write_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [3:0]    byteen_a, byteen_b;
    logic [31:0]   wdata_a, wdata_b, mem_rdata;

    logic          gnt_a [3];
    logic          gnt_b [3];
    logic          rvalid_a [3];
    logic          rvalid_b [3];
    logic [31:0]   rdata_a [3];
    logic [31:0]   rdata_b [3];
    logic          mem_ren [3];
    logic          mem_wen [3];
    logic [AW-1:0] mem_addr [3];
    logic [3:0]    mem_byteen [3];
    logic [31:0]   mem_wdata [3];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_port_arbiter #(
            .MEM_AWIDTH(AW),
            .RD_LATENCY(g + 1)
        ) u_dut (
            .HCLK      (HCLK),
            .HRESETN   (HRESETN),
            .req_a     (req_a),
            .lock_a    (lock_a),
            .write_a   (write_a),
            .addr_a    (addr_a),
            .byteen_a  (byteen_a),
            .wdata_a   (wdata_a),
            .req_b     (req_b),
            .lock_b    (lock_b),
            .write_b   (write_b),
            .addr_b    (addr_b),
            .byteen_b  (byteen_b),
            .wdata_b   (wdata_b),
            .gnt_a     (gnt_a[g]),
            .rvalid_a  (rvalid_a[g]),
            .rdata_a   (rdata_a[g]),
            .gnt_b     (gnt_b[g]),
            .rvalid_b  (rvalid_b[g]),
            .rdata_b   (rdata_b[g]),
            .mem_ren   (mem_ren[g]),
            .mem_wen   (mem_wen[g]),
            .mem_addr  (mem_addr[g]),
            .mem_byteen(mem_byteen[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input int g, input logic ea, input logic eb);
        chk({tag, "_gnt_a"}, {31'b0, gnt_a[g]}, {31'b0, ea});
        chk({tag, "_gnt_b"}, {31'b0, gnt_b[g]}, {31'b0, eb});
    endtask

    task automatic chk_mem(input string tag, input int g, input logic ren, input logic wen,
                           input logic [AW-1:0] addr, input logic [3:0] be);
        chk({tag, "_ren"},    {31'b0, mem_ren[g]}, {31'b0, ren});
        chk({tag, "_wen"},    {31'b0, mem_wen[g]}, {31'b0, wen});
        chk({tag, "_addr"},   {16'b0, mem_addr[g]}, {16'b0, addr});
        chk({tag, "_byteen"}, {28'b0, mem_byteen[g]}, {28'b0, be});
    endtask

    task automatic chk_rd(input string tag, input int g, input logic va, input logic [31:0] da,
                          input logic vb, input logic [31:0] db);
        chk({tag, "_rvalid_a"}, {31'b0, rvalid_a[g]}, {31'b0, va});
        chk({tag, "_rdata_a"},  rdata_a[g], da);
        chk({tag, "_rvalid_b"}, {31'b0, rvalid_b[g]}, {31'b0, vb});
        chk({tag, "_rdata_b"},  rdata_b[g], db);
    endtask

    task automatic idle_inputs();
        req_a = 0; lock_a = 0; write_a = 0; addr_a = '0; byteen_a = '0; wdata_a = '0;
        req_b = 0; lock_b = 0; write_b = 0; addr_b = '0; byteen_b = '0; wdata_b = '0;
    endtask

    task automatic do_reset();
        HRESETN = 1'b0;
        idle_inputs();
        repeat (2) @(negedge HCLK);
        HRESETN = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        mem_rdata = 32'h0;
        repeat (2) @(negedge HCLK);

        // reset state, with both requesting: no grant allowed while in reset
        req_a = 1; req_b = 1;
        #1;
        chk_gnt("rst", 0, 0, 0);
        chk_mem("rst", 0, 0, 0, 16'h0, 4'h0);
        chk("rst_wdata", mem_wdata[0], 32'h0);
        chk_rd("rst", 0, 0, 32'h0, 0, 32'h0);
        req_a = 0; req_b = 0;
        @(negedge HCLK);
        HRESETN = 1'b1;

        // single read, RD_LATENCY=1 on instance 0
        req_a = 1; write_a = 0; addr_a = 16'h0010;
        #1 chk_gnt("t1_c0", 0, 1, 0);
        @(negedge HCLK);
        req_a = 0; mem_rdata = 32'hDEADBEEF;
        #1 chk_mem("t1_c1", 0, 1, 0, 16'h0010, 4'hF);
        chk_rd("t1_c1", 0, 0, 32'h0, 0, 32'h0);
        @(negedge HCLK);
        #1 chk_rd("t1_c2", 0, 1, 32'hDEADBEEF, 0, 32'h0);
        chk_mem("t1_c2", 0, 0, 0, 16'h0010, 4'hF);
        @(negedge HCLK);
        mem_rdata = 32'h12345678;
        #1 chk_rd("t1_c3", 0, 0, 32'h0, 0, 32'h0);
        chk_rd("t1_l2", 1, 1, 32'h12345678, 0, 32'h0);

        // contention: a reads, b writes, both held four cycles
        do_reset();
        addr_a = 16'h0100; write_a = 0; wdata_a = 32'h0000000A;
        addr_b = 16'h0200; write_b = 1; byteen_b = 4'b0101; wdata_b = 32'hCAFE0002;
        req_a = 1; req_b = 1;
        for (int i = 0; i < 4; i++) begin
            #1 chk_gnt($sformatf("t2_c%0d", i), 0, (i % 2 == 0), (i % 2 == 1));
            if (i > 0) begin
                if ((i - 1) % 2 == 0)
                    chk_mem($sformatf("t2_m%0d", i), 0, 1, 0, 16'h0100, 4'hF);
                else
                    chk_mem($sformatf("t2_m%0d", i), 0, 0, 1, 16'h0200, 4'b0101);
            end
            @(negedge HCLK);
        end
        req_a = 0; req_b = 0;
        #1 chk_mem("t2_m4", 0, 0, 1, 16'h0200, 4'b0101);
        chk("t2_wdata", mem_wdata[0], 32'hCAFE0002);
        chk_gnt("t2_c4", 0, 0, 0);
        @(negedge HCLK);
        #1 chk_mem("t2_m5", 0, 0, 0, 16'h0200, 4'b0101);

        // lock: a holds the port, then lock without request idles the port
        do_reset();
        req_a = 1; lock_a = 1; write_a = 1; addr_a = 16'h0030; byteen_a = 4'hF;
        req_b = 1; write_b = 0; addr_b = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            #1 chk_gnt($sformatf("t3_c%0d", i), 0, 1, 0);
            @(negedge HCLK);
        end
        req_a = 0;
        #1 chk_gnt("t3_blk", 0, 0, 0);
        chk_mem("t3_blk", 0, 0, 1, 16'h0030, 4'hF);
        @(negedge HCLK);
        lock_a = 0;
        #1 chk_gnt("t3_rel", 0, 0, 1);
        chk_mem("t3_idle", 0, 0, 0, 16'h0030, 4'hF);
        @(negedge HCLK);
        req_b = 0;
        #1 chk_mem("t3_b", 0, 1, 0, 16'h0040, 4'hF);

        // mixed order on instance 2 (RD_LATENCY=3)
        do_reset();
        mem_rdata = 32'hD0000001;
        req_a = 1; write_a = 0; addr_a = 16'h0001;
        req_b = 1; write_b = 1; addr_b = 16'h0002; byteen_b = 4'b0011; wdata_b = 32'h0000BEEF;
        #1 chk_gnt("t4_c1", 2, 1, 0);
        @(negedge HCLK);
        mem_rdata = 32'hD0000002; addr_a = 16'h0003;
        #1 chk_gnt("t4_c2", 2, 0, 1);
        chk_mem("t4_c2", 2, 1, 0, 16'h0001, 4'hF);
        @(negedge HCLK);
        mem_rdata = 32'hD0000003; req_b = 0;
        #1 chk_gnt("t4_c3", 2, 1, 0);
        chk_mem("t4_c3", 2, 0, 1, 16'h0002, 4'b0011);
        @(negedge HCLK);
        mem_rdata = 32'hD0000004; req_a = 0;
        #1 chk_mem("t4_c4", 2, 1, 0, 16'h0003, 4'hF);
        chk_rd("t4_c4", 2, 0, 32'h0, 0, 32'h0);
        @(negedge HCLK);
        mem_rdata = 32'hD0000005;
        #1 chk_rd("t4_c5", 2, 1, 32'hD0000005, 0, 32'h0);
        @(negedge HCLK);
        mem_rdata = 32'hD0000006;
        #1 chk_rd("t4_c6", 2, 0, 32'h0, 0, 32'h0);
        @(negedge HCLK);
        mem_rdata = 32'hD0000007;
        #1 chk_rd("t4_c7", 2, 1, 32'hD0000007, 0, 32'h0);
        @(negedge HCLK);
        #1 chk_rd("t4_c8", 2, 0, 32'h0, 0, 32'h0);

        // reset one cycle after a read grant on instance 1 (RD_LATENCY=2)
        do_reset();
        mem_rdata = 32'h00000BAD;
        req_a = 1; write_a = 0; addr_a = 16'h0055;
        #1 chk_gnt("t5_c1", 1, 1, 0);
        @(negedge HCLK);
        req_a = 0;
        #1 chk("t5_c2_ren", {31'b0, mem_ren[1]}, 32'h1);
        HRESETN = 1'b0; req_a = 1; req_b = 1;
        #1 chk_gnt("t5_rst", 1, 0, 0);
        chk_mem("t5_rst", 1, 0, 0, 16'h0, 4'h0);
        chk("t5_rst_wdata", mem_wdata[1], 32'h0);
        chk_rd("t5_rst", 1, 0, 32'h0, 0, 32'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        req_a = 0; req_b = 0; HRESETN = 1'b1;
        #1 chk_rd("t5_c4", 1, 0, 32'h0, 0, 32'h0);
        @(negedge HCLK);
        #1 chk_rd("t5_c5", 1, 0, 32'h0, 0, 32'h0);
        chk_rd("t5_c5_l3", 2, 0, 32'h0, 0, 32'h0);
        req_a = 1; req_b = 1;
        #1 chk_gnt("t5_first", 1, 1, 0);
        @(negedge HCLK);
        idle_inputs();
        @(negedge HCLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_AWIDTH, default 16, giving the fabric SRAM word-address width.
REQ-002 SHALL have parameter RD_LATENCY, default 1, giving the cycles from mem_ren asserted to mem_rdata valid; legal range 1..4.
REQ-003 SHALL have port HCLK, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port HRESETN, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have, for each requester x in {a,b}, these inputs: req_x (1), lock_x (1), write_x (1), addr_x (MEM_AWIDTH), byteen_x (4), wdata_x (32).
REQ-006 SHALL have, for each requester x in {a,b}, these outputs: gnt_x (1), rvalid_x (1), rdata_x (32).
REQ-007 SHALL have fabric SRAM side outputs mem_ren (1), mem_wen (1), mem_addr (MEM_AWIDTH), mem_byteen (4), mem_wdata (32), and input mem_rdata (32).

Function
REQ-008 SHALL compute gnt_x combinationally; at most one gnt is high per cycle, and gnt_x is only high when req_x is high.
REQ-009 A requester SHALL hold req and all request fields stable until it sees gnt; a granted request is consumed in that cycle.
REQ-010 SHALL arbitrate round-robin with a 1-bit priority pointer: a single requester wins; if both request, the pointed-to requester wins.
REQ-011 After each grant, the pointer SHALL point to the non-granted requester.
REQ-012 Lock: while lock_x is high and the last grant went to x, the other requester SHALL be denied; lock_x with req_x low leaves the port idle and blocks the other requester.
REQ-013 Lock SHALL release in the first cycle lock_x is low, and normal round-robin resumes in that cycle.
REQ-014 A grant in cycle T SHALL produce registered mem outputs in cycle T+1:
- write: mem_wen=1, mem_byteen=byteen_x
- read: mem_ren=1, mem_byteen=4'hF
- both cases: mem_addr=addr_x, mem_wdata=wdata_x
REQ-015 In cycles with no grant, mem_ren and mem_wen SHALL be 0 the next cycle and the other mem outputs SHALL hold their values.
REQ-016 A write with byteen_x=0 SHALL still be issued; write data is never returned.
REQ-017 SHALL track in-flight reads in a RD_LATENCY-deep shift pipeline of {valid, owner}, advancing every cycle, so back-to-back reads are supported.
REQ-018 Read return: rvalid_owner SHALL pulse for one cycle at T+1+RD_LATENCY with rdata_owner=mem_rdata; the non-owner's rdata SHALL be 0.
REQ-019 rdata_x SHALL be 0 whenever rvalid_x is 0.
REQ-020 Throughput SHALL be one access per cycle, with no bubble on grant switches.
REQ-021 Read returns SHALL be delivered in issue order; a write issued between reads SHALL NOT disturb the read pipeline.

Reset
REQ-022 On HRESETN low:
- mem_ren=0, mem_wen=0, mem_addr=0, mem_byteen=0, mem_wdata=0
- rvalid_a=0, rvalid_b=0, rdata_a=0, rdata_b=0
- read pipeline cleared; priority pointer set to requester a; lock ownership cleared
REQ-023 Reads in flight when reset asserts SHALL be discarded and never produce rvalid.
REQ-024 gnt_x SHALL be 0 while HRESETN is low.

Structure
REQ-025 The shared package SHALL hold the requester-ID encoding (REQ_A=0, REQ_B=1), the full byte-enable constant 4'hF and the RD_LATENCY legal maximum.
REQ-026 The read-return pipeline SHALL be one sub-module, sram_rd_tracker (parameter RD_LATENCY; input valid/owner; output rvalid per owner).
REQ-027 The arbiter, lock logic and mem output registers SHALL stay in the top module.

Verification
REQ-028 Single read: req_a read addr 0x0010 at T, RD_LATENCY=1, mem_rdata=0xDEADBEEF at T+2 -> gnt_a at T; mem_ren=1, mem_addr=0x0010 at T+1; rvalid_a=1, rdata_a=0xDEADBEEF at T+2; rvalid_b=0.
REQ-029 Contention: req_a and req_b held high for 4 cycles after reset -> grants a,b,a,b; mem_ren/mem_wen high in 4 consecutive cycles.
REQ-030 Lock: lock_a=1 with req_a for 3 cycles while req_b is held -> gnt_a x3, gnt_b=0; lock_a drops -> gnt_b next cycle.
REQ-031 Mixed order: RD_LATENCY=3; a read addr 1, b write addr 2 byteen 4'b0011, a read addr 3 back-to-back -> mem_byteen F,3,F; two rvalid_a pulses in order; no rvalid_b.
REQ-032 Reset mid-flight: HRESETN low one cycle after a read grant with RD_LATENCY=2 -> no rvalid; all outputs 0; first grant after reset goes to a when both request.
